// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// master drives operands and out_ready; slave (the adder) drives results and in_ready.
interface pipe_addsub_if #(
  parameter int unsigned LENGTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] A;
  logic [LENGTH-1:0] B;
  logic              sub;
  logic              signed_mode;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] Result;
  logic              carry;
  logic              overflow;
  logic              zero;
  logic              negative;

  modport master (
    output in_valid, A, B, sub, signed_mode, out_ready,
    input  in_ready, out_valid, Result, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, A, B, sub, signed_mode, out_ready,
    output in_ready, out_valid, Result, carry, overflow, zero, negative
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: STAGES carry-chained chunks with carry/overflow/zero/negative flags.
// Define PIPE_ADDSUB_SAT_EN to saturate overflowing results in the final stage.
module pipe_addsub #(
  parameter int unsigned LENGTH = 32,
  parameter int unsigned STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  pipe_addsub_if.slave bus
);
  localparam int unsigned CW  = LENGTH / STAGES;
  localparam int unsigned LO  = (STAGES - 1) * CW;
  localparam int unsigned MSB = LENGTH - 1;

  typedef struct packed {
    logic              vld;
    logic              sub;
    logic              sm;
    logic              cy;
    logic [LENGTH-1:0] a;
    logic [LENGTH-1:0] be;
    logic [LENGTH-1:0] sum;
  } stage_t;

  logic              r_out_valid;
  logic [LENGTH-1:0] r_result;
  logic              r_carry;
  logic              r_overflow;
  logic              r_zero;
  logic              r_negative;

  logic              w_stall;
  stage_t            w_src [STAGES];

  assign w_stall      = r_out_valid & ~bus.out_ready;
  assign bus.in_ready = ~w_stall & ~reset;

  // Stage 0 source: B pre-inverted for subtract, carry-in seeded with sub.
  assign w_src[0] = '{
    vld: bus.in_valid & bus.in_ready,
    sub: bus.sub,
    sm:  bus.signed_mode,
    cy:  bus.sub,
    a:   bus.A,
    be:  bus.sub ? ~bus.B : bus.B,
    sum: '0
  };

  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    logic [CW:0]       w_add;
    logic [LENGTH-1:0] w_sum;
    stage_t            r_pipe;

    assign w_add = {1'b0, w_src[k].a[k*CW +: CW]} + {1'b0, w_src[k].be[k*CW +: CW]}
                 + {{CW{1'b0}}, w_src[k].cy};

    always_comb begin
      w_sum              = w_src[k].sum;
      w_sum[k*CW +: CW]  = w_add[CW-1:0];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_pipe <= '0;
      end else if (!w_stall) begin
        r_pipe <= '{
          vld: w_src[k].vld,
          sub: w_src[k].sub,
          sm:  w_src[k].sm,
          cy:  w_add[CW],
          a:   w_src[k].a,
          be:  w_src[k].be,
          sum: w_sum
        };
      end
    end

    assign w_src[k+1] = r_pipe;
  end

  // Final stage: top chunk, flags and optional saturation.
  logic [CW:0]       w_fadd;
  logic [LENGTH-1:0] w_raw;
  logic [LENGTH-1:0] w_res;
  logic              w_carry;
  logic              w_sovf;
  logic              w_uovf;
  logic              w_ovf;

  assign w_fadd = {1'b0, w_src[STAGES-1].a[LO +: CW]} + {1'b0, w_src[STAGES-1].be[LO +: CW]}
                + {{CW{1'b0}}, w_src[STAGES-1].cy};

  always_comb begin
    w_raw            = w_src[STAGES-1].sum;
    w_raw[LO +: CW]  = w_fadd[CW-1:0];
  end

  assign w_carry = w_fadd[CW];
  assign w_sovf  = (w_src[STAGES-1].a[MSB] == w_src[STAGES-1].be[MSB]) &&
                   (w_raw[MSB] != w_src[STAGES-1].a[MSB]);
  assign w_uovf  = w_carry ^ w_src[STAGES-1].sub;
  assign w_ovf   = w_src[STAGES-1].sm ? w_sovf : w_uovf;

`ifdef PIPE_ADDSUB_SAT_EN
  always_comb begin
    w_res = w_raw;
    if (w_src[STAGES-1].sm && w_sovf) begin
      // Operand sign tells the overflow direction.
      w_res = w_src[STAGES-1].a[MSB] ? {1'b1, {(LENGTH-1){1'b0}}} : {1'b0, {(LENGTH-1){1'b1}}};
    end else if (!w_src[STAGES-1].sm && w_uovf) begin
      w_res = w_src[STAGES-1].sub ? '0 : '1;
    end
  end
`else
  assign w_res = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_src[STAGES-1].vld;
      if (w_src[STAGES-1].vld) begin
        r_result   <= w_res;
        r_carry    <= w_carry;
        r_overflow <= w_ovf;
        r_zero     <= (w_res == '0);
        r_negative <= w_res[MSB];
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.Result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed cases plus randomized streams checked against an arithmetic model
// on three configurations (32/2, 16/1, 16/4).
module tb_pipe_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int          sel;
  logic        t_in_valid, t_sub, t_sm, t_out_ready;
  logic [31:0] t_a, t_b;
  int          errors, checks;

  pipe_addsub_if #(.LENGTH(32)) i32 ();
  pipe_addsub_if #(.LENGTH(16)) i16a ();
  pipe_addsub_if #(.LENGTH(16)) i16b ();

  pipe_addsub #(.LENGTH(32), .STAGES(2)) dut32  (.clk(clk), .reset(reset), .bus(i32));
  pipe_addsub #(.LENGTH(16), .STAGES(1)) dut16a (.clk(clk), .reset(reset), .bus(i16a));
  pipe_addsub #(.LENGTH(16), .STAGES(4)) dut16b (.clk(clk), .reset(reset), .bus(i16b));

  assign i32.in_valid     = t_in_valid && (sel == 0);
  assign i32.A            = t_a;
  assign i32.B            = t_b;
  assign i32.sub          = t_sub;
  assign i32.signed_mode  = t_sm;
  assign i32.out_ready    = (sel == 0) ? t_out_ready : 1'b1;
  assign i16a.in_valid    = t_in_valid && (sel == 1);
  assign i16a.A           = t_a[15:0];
  assign i16a.B           = t_b[15:0];
  assign i16a.sub         = t_sub;
  assign i16a.signed_mode = t_sm;
  assign i16a.out_ready   = (sel == 1) ? t_out_ready : 1'b1;
  assign i16b.in_valid    = t_in_valid && (sel == 2);
  assign i16b.A           = t_a[15:0];
  assign i16b.B           = t_b[15:0];
  assign i16b.sub         = t_sub;
  assign i16b.signed_mode = t_sm;
  assign i16b.out_ready   = (sel == 2) ? t_out_ready : 1'b1;

  logic        g_in_ready, g_out_valid;
  logic [31:0] g_result;
  logic [3:0]  g_flags;  // {carry, overflow, zero, negative}

  always_comb begin
    g_in_ready  = i32.in_ready;
    g_out_valid = i32.out_valid;
    g_result    = i32.Result;
    g_flags     = {i32.carry, i32.overflow, i32.zero, i32.negative};
    if (sel == 1) begin
      g_in_ready  = i16a.in_ready;
      g_out_valid = i16a.out_valid;
      g_result    = {16'h0, i16a.Result};
      g_flags     = {i16a.carry, i16a.overflow, i16a.zero, i16a.negative};
    end else if (sel == 2) begin
      g_in_ready  = i16b.in_ready;
      g_out_valid = i16b.out_valid;
      g_result    = {16'h0, i16b.Result};
      g_flags     = {i16b.carry, i16b.overflow, i16b.zero, i16b.negative};
    end
  end

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  function automatic int width_of(int s);
    return (s == 0) ? 32 : 16;
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : ((s == 1) ? 1 : 4);
  endfunction

  // Reference: true integer arithmetic, then wrap or clamp into w bits.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic sm);
    exp_t   e;
    longint mask, half, ua, ub, sa, sb, raw_u, raw_s, r;
    logic   cy, sovf, uovf;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(a) & mask;
    ub    = longint'(b) & mask;
    sa    = (ua >= half) ? ua - (mask + 1) : ua;
    sb    = (ub >= half) ? ub - (mask + 1) : ub;
    raw_u = sub ? ua - ub : ua + ub;
    raw_s = sub ? sa - sb : sa + sb;
    cy    = sub ? (ua >= ub) : (raw_u > mask);
    uovf  = sub ? (ua < ub) : (raw_u > mask);
    sovf  = (raw_s > half - 1) || (raw_s < -half);
    r     = raw_u & mask;
`ifdef PIPE_ADDSUB_SAT_EN
    if (sm && sovf) r = (raw_s > 0) ? half - 1 : half;
    else if (!sm && uovf) r = sub ? 0 : mask;
`endif
    e.res   = 32'(r);
    e.flags = {cy, sm ? sovf : uovf, r == 0, ((r >> (w - 1)) & 1) != 0};
    return e;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] c [8];
    c = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
          32'h0000_FFFF, 32'h1, 32'h7FFF, 32'h8000};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 7)];
    return $urandom();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation with explicit expectations and latency checks.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sm, input logic [31:0] eres,
                         input logic [3:0] ef);
    int lat;
    lat = lat_of(sel);
    t_a = a; t_b = b; t_sub = sub; t_sm = sm; t_in_valid = 1'b1; t_out_ready = 1'b1;
    #1;
    chk({tag, ".accept"}, g_in_ready, 1);
    tick();
    t_in_valid = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk({tag, ".early"}, g_out_valid, 0);
      tick();
    end
    chk({tag, ".valid"}, g_out_valid, 1);
    chk({tag, ".result"}, g_result, eres);
    chk({tag, ".flags"}, g_flags, ef);
    tick();
    chk({tag, ".drop"}, g_out_valid, 0);
  endtask

  task automatic run_random(input string tag, input int n);
    exp_t q[$];
    exp_t e;
    int   w;
    w = width_of(sel);
    for (int i = 0; i < n + 12; i++) begin
      if (i < n) begin
        t_in_valid  = ($urandom_range(0, 3) != 0);
        t_a         = rnd_op();
        t_b         = rnd_op();
        t_sub       = 1'($urandom_range(0, 1));
        t_sm        = 1'($urandom_range(0, 1));
        t_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        t_in_valid  = 1'b0;
        t_out_ready = 1'b1;
      end
      #1;
      chk({tag, ".in_ready"}, g_in_ready, !(g_out_valid && !t_out_ready));
      if (g_out_valid && t_out_ready) begin
        if (q.size() == 0) begin
          chk({tag, ".spurious"}, 1, 0);
        end else begin
          e = q.pop_front();
          chk({tag, ".result"}, g_result, e.res);
          chk({tag, ".flags"}, g_flags, e.flags);
        end
      end
      if (t_in_valid && g_in_ready) q.push_back(model(w, t_a, t_b, t_sub, t_sm));
      tick();
    end
    chk({tag, ".drained"}, q.size(), 0);
  endtask

  initial begin
    logic [31:0] got[$];
    logic [31:0] held_val;
    logic        held;
    int          idx, stalls;

    errors = 0; checks = 0; sel = 0;
    t_in_valid = 1'b0; t_a = '0; t_b = '0; t_sub = 1'b0; t_sm = 1'b0; t_out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk("rst.in_ready32", i32.in_ready, 0);
    chk("rst.valid32", i32.out_valid, 0);
    chk("rst.result32", i32.Result, 0);
    chk("rst.flags32", {i32.carry, i32.overflow, i32.zero, i32.negative}, 0);
    chk("rst.valid16a", i16a.out_valid, 0);
    chk("rst.state16a", {i16a.Result, i16a.carry, i16a.overflow, i16a.zero, i16a.negative}, 0);
    chk("rst.valid16b", i16b.out_valid, 0);
    chk("rst.state16b", {i16b.Result, i16b.carry, i16b.overflow, i16b.zero, i16b.negative}, 0);
    reset = 1'b0;
    #1;
    chk("rst.in_ready_after", g_in_ready, 1);

    run_one("add_chunk", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 4'b0000);
    run_one("sub_eq", 32'd5, 32'd5, 1'b1, 1'b0, 32'h0, 4'b1010);
    run_one("sub_neg", 32'd3, 32'd5, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0001);
`ifdef PIPE_ADDSUB_SAT_EN
    run_one("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
`else
    run_one("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 4'b0101);
`endif

    // Backpressure: four back-to-back adds with out_ready low for three cycles.
    idx = 0; stalls = 0; held = 1'b0; held_val = '0;
    t_sub = 1'b0; t_sm = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      t_out_ready = !(cyc >= 3 && cyc <= 5);
      t_in_valid  = (idx < 4);
      t_a         = 32'(idx + 1);
      t_b         = 32'(idx + 1);
      #1;
      if (g_out_valid && !t_out_ready) begin
        stalls++;
        chk("bp.in_ready", g_in_ready, 0);
      end
      if (held) chk("bp.hold", g_result, held_val);
      held     = g_out_valid && !t_out_ready;
      held_val = g_result;
      if (g_out_valid && t_out_ready) got.push_back(g_result);
      if (t_in_valid && g_in_ready) idx++;
      tick();
    end
    chk("bp.stalls", stalls, 3);
    chk("bp.count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp.order", got[i], 32'(2 * (i + 1)));
    end

    // Reset with two operations in flight.
    t_out_ready = 1'b1; t_in_valid = 1'b1; t_a = 32'd10; t_b = 32'd20;
    #1;
    tick();
    t_a = 32'd30; t_b = 32'd40;
    tick();
    t_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rmid.in_ready", g_in_ready, 0);
    tick();
    reset = 1'b0;
    chk("rmid.valid", g_out_valid, 0);
    chk("rmid.result", g_result, 0);
    chk("rmid.flags", g_flags, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rmid.stale", g_out_valid, 0);
    end
    run_one("post_rst", 32'd6, 32'd7, 1'b0, 1'b0, 32'd13, 4'b0000);

    run_random("rnd32", 400);

    sel = 1;
    run_one("s1_wrap", 32'hFFFF, 32'h1, 1'b0, 1'b1, 32'h0, 4'b1010);
    run_random("rnd16s1", 200);

    sel = 2;
    run_one("s4_wrap", 32'hFFFF, 32'h1, 1'b0, 1'b1, 32'h0, 4'b1010);
    run_random("rnd16s4", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
